// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Purpose : Shared encodings for the multi-cycle hazard controller:
//           forward-select codes, result-source codes and FSM state codes.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Operand forward-select encodings driven onto ForwardAE/ForwardBE
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file value
  localparam logic [1:0] FWD_W     = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M_ALU = 2'b10;  // ALUResultM
  localparam logic [1:0] FWD_M_IMM = 2'b11;  // ImmM (LUI in M)

  // Result-source encodings carried down the pipe
  localparam logic [1:0] RES_LOAD  = 2'b01;
  localparam logic [1:0] RES_IMM   = 2'b11;

  // Hazard FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_LOAD_WAIT = 2'd1;
  localparam state_t ST_MDU_BUSY  = 2'd2;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module  : fwd_sel
// Purpose : Priority compare producing the 2-bit forward select for one
//           execute-stage source operand.
// Ports   : rs_i            - source register address in E
//           rd_m_i/rd_w_i   - destination addresses in M / W
//           reg_write_m_i/w - writeback enables of M / W
//           result_src_m_i  - result select of the M instruction
//           fwd_o           - forward select (FWD_* encoding)
// Revision: 1.0 - initial release
// ============================================================================
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter bit FWD_IMM = 1'b1
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  input  logic [1:0]        result_src_m_i,
  output logic [1:0]        fwd_o
);

  logic rs_nz;
  logic hit_m;
  logic hit_w;

  // x0 is hard-wired to zero, so neither M nor W may ever forward into it
  assign rs_nz = (rs_i != '0);
  assign hit_m = rs_nz && reg_write_m_i && (rs_i == rd_m_i);
  assign hit_w = rs_nz && reg_write_w_i && (rs_i == rd_w_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (hit_m) begin
      // A LUI result in M has no ALU result yet worth taking; use ImmM
      if (FWD_IMM && (result_src_m_i == RES_IMM)) fwd_o = FWD_M_IMM;
      else                                          fwd_o = FWD_M_ALU;
    end else if (hit_w) begin
      fwd_o = FWD_W;
    end
  end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_mc
// Purpose : Hazard controller for the 5-stage RV32I pipeline with a
//           multi-cycle MDU occupancy FSM, configurable load-use bubbles,
//           operand forwarding and saturating stall/flush counters.
// Ports   : clk, rst                      - clock, sync active-high reset
//           RegWriteM/W, ResultSrcE/M/W   - pipeline control inputs
//           PCSrcE, MduStartE             - branch taken / MDU op in E
//           Rs1D,Rs2D,Rs1E,Rs2E,RdE,RdM,RdW - register addresses
//           StallF/D/E, FlushD/E/M        - pipeline register controls
//           ForwardAE/BE                  - operand forward selects
//           MduBusy                       - FSM in MDU_BUSY
//           StallCycles, FlushEvents      - saturating perf counters
// Revision: 1.0 - initial release
// ============================================================================
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int MDU_LAT      = 4,
  parameter int LOAD_BUBBLES = 1,
  parameter bit FWD_IMM      = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic [1:0]        ResultSrcM,
  input  logic [1:0]        ResultSrcW,
  input  logic              PCSrcE,
  input  logic              MduStartE,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MduBusy,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushEvents
);

  localparam int LW_W  = $clog2(LOAD_BUBBLES + 1);
  localparam int MDU_W = $clog2(MDU_LAT + 1);

  localparam logic [LW_W-1:0]  LW_LOAD    = LW_W'(LOAD_BUBBLES - 1);
  localparam logic [MDU_W-1:0] MDU_LOAD   = MDU_W'((MDU_LAT >= 2) ? (MDU_LAT - 2) : 0);
  localparam bit               MDU_MULTI  = (MDU_LAT >= 2);
  localparam bit               LW_MULTI   = (LOAD_BUBBLES > 1);

  state_t            state_q, state_d, state_cur;
  logic [LW_W-1:0]   lw_cnt_q, lw_cnt_d;
  logic [MDU_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic lw_hit;
  logic stall_fd;
  logic stall_e;
  logic flush_m;
  logic lw_flush;
  logic busy;
  logic br_flush;

  // ResultW is never forwarded by type, so ResultSrcW carries no hazard info
  logic unused_ok;
  assign unused_ok = ^ResultSrcW;

  // --------------------------------------------------------------------------
  // Forwarding: one priority comparator per execute operand
  // --------------------------------------------------------------------------
  fwd_sel #(.REG_AW(REG_AW), .FWD_IMM(FWD_IMM)) u_fwd_a (
    .rs_i           (Rs1E),
    .rd_m_i         (RdM),
    .rd_w_i         (RdW),
    .reg_write_m_i  (RegWriteM),
    .reg_write_w_i  (RegWriteW),
    .result_src_m_i (ResultSrcM),
    .fwd_o          (ForwardAE)
  );

  fwd_sel #(.REG_AW(REG_AW), .FWD_IMM(FWD_IMM)) u_fwd_b (
    .rs_i           (Rs2E),
    .rd_m_i         (RdM),
    .rd_w_i         (RdW),
    .reg_write_m_i  (RegWriteM),
    .reg_write_w_i  (RegWriteW),
    .result_src_m_i (ResultSrcM),
    .fwd_o          (ForwardBE)
  );

  // --------------------------------------------------------------------------
  // Hazard FSM (next-state and control decode)
  // --------------------------------------------------------------------------
  assign lw_hit = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));

  // Reset forces the decode to IDLE so an aborted MDU/load sequence leaves
  // no residual stall even in the reset cycle itself.
  assign state_cur = rst ? ST_IDLE : state_q;

  always_comb begin
    state_d   = state_cur;
    lw_cnt_d  = lw_cnt_q;
    mdu_cnt_d = mdu_cnt_q;
    stall_fd  = 1'b0;
    stall_e   = 1'b0;
    flush_m   = 1'b0;
    lw_flush  = 1'b0;
    case (state_cur)
      ST_IDLE: begin
        // An MDU op in E means E cannot hold a load, so MDU takes precedence
        if (MduStartE) begin
          if (MDU_MULTI) begin
            stall_fd  = 1'b1;
            stall_e   = 1'b1;
            flush_m   = 1'b1;
            mdu_cnt_d = MDU_LOAD;
            state_d   = ST_MDU_BUSY;
          end
        end else if (lw_hit) begin
          stall_fd = 1'b1;
          lw_flush = 1'b1;
          if (LW_MULTI) begin
            lw_cnt_d = LW_LOAD;
            state_d  = ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        stall_fd = 1'b1;
        lw_flush = 1'b1;
        lw_cnt_d = lw_cnt_q - LW_W'(1);
        if (lw_cnt_q <= LW_W'(1)) state_d = ST_IDLE;
      end
      ST_MDU_BUSY: begin
        // Count of zero marks the final occupancy cycle: the op advances
        if (mdu_cnt_q != '0) begin
          stall_fd  = 1'b1;
          stall_e   = 1'b1;
          flush_m   = 1'b1;
          mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_cur == ST_MDU_BUSY);
  // E holds the MDU op while busy, so a branch indication there is stale
  assign br_flush = PCSrcE && !busy;

  assign StallF  = stall_fd;
  assign StallD  = stall_fd;
  assign StallE  = stall_e;
  assign FlushD  = br_flush;
  assign FlushE  = br_flush || lw_flush;
  assign FlushM  = flush_m;
  assign MduBusy = busy;

  // --------------------------------------------------------------------------
  // State and saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lw_cnt_q    <= '0;
      mdu_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lw_cnt_q  <= lw_cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
      if (stall_fd && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushEvents = flush_cnt_q;

endmodule : hazard_ctrl_mc
`default_nettype wire

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised hazard controller for the 5-stage RV32I pipeline, successor to the single-cycle hazard unit. It adds:
- a multi-cycle execute (MUL/DIV) occupancy FSM,
- a configurable load-use bubble count,
- corrected operand-forwarding priority,
- saturating stall and flush performance counters.

It sits beside the datapath and drives the stall, flush and forward-select controls of the F/D/E/M pipeline registers.

## Interface
Parameters:
- REG_AW, 5, register address width
- MDU_LAT, 4, cycles a multi-cycle op occupies E (≥1)
- LOAD_BUBBLES, 1, bubbles inserted on load-use (≥1)
- FWD_IMM, 1, enable forwarding of ImmM for LUI results in M
- CNT_W, 16, performance counter width

Ports:
- clk in 1 — single clock; all state on rising edge
- rst in 1 — synchronous, active-high
- RegWriteM, RegWriteW in 1 — writeback enables of M, W
- ResultSrcE, ResultSrcM, ResultSrcW in 2 — result select (01 load, 11 immediate)
- PCSrcE in 1 — taken branch/jump resolved in E
- MduStartE in 1 — multi-cycle op present in E this cycle
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW in REG_AW — register addresses
- StallF, StallD, StallE out 1 — hold PC, IF/ID, ID/EX
- FlushD, FlushE, FlushM out 1 — bubble IF/ID, ID/EX, EX/MEM
- ForwardAE, ForwardBE out 2 — 00 regfile, 01 ResultW, 10 ALUResultM, 11 ImmM
- MduBusy out 1 — FSM in MDU_BUSY
- StallCycles, FlushEvents out CNT_W — performance counters

## Operation
Forwarding, per operand; x0 is never forwarded:
- RsE==RdM, RegWriteM, ResultSrcM==11, FWD_IMM → 11.
- Otherwise RsE==RdM, RegWriteM → 10.
- Otherwise RsE==RdW, RegWriteW → 01.
- Otherwise 00.
- The x0 check applies to every arm, fixing the predecessor's precedence bug on the W arm.

Load-use:
- lwHit = ResultSrcE==01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- lwHit → StallF, StallD, FlushE in the same cycle.
- If LOAD_BUBBLES>1: load lwCnt=LOAD_BUBBLES-1 and enter LOAD_WAIT.
- In LOAD_WAIT: StallF, StallD, FlushE each cycle; decrement lwCnt; at 1, next state is IDLE.

MDU:
- In IDLE with MduStartE and MDU_LAT≥2: StallF, StallD, StallE, FlushM; load mduCnt=MDU_LAT-2; enter MDU_BUSY.
- In MDU_BUSY with mduCnt≠0: same four outputs; decrement.
- In MDU_BUSY with mduCnt==0: no stall; op advances; return to IDLE.
- Total E occupancy is exactly MDU_LAT cycles. MDU_LAT==1 never stalls.
- MduStartE is ignored outside IDLE.

Branch:
- FlushD = PCSrcE.
- FlushE = PCSrcE | load-use term.
- PCSrcE is ignored while MduBusy, since E holds the MDU op.

Counters:
- StallCycles increments on every cycle with StallF.
- FlushEvents increments on every PCSrcE (outside MDU_BUSY).
- Both saturate at all-ones; no wrap.

## Timing
- FSM states: IDLE, LOAD_WAIT, MDU_BUSY. Reset state IDLE.
- All control outputs are combinational from inputs and registered state; zero-cycle latency from hazard to stall.
- Under rst: state=IDLE, lwCnt=mduCnt=0, counters=0. All stall/flush/forward outputs read 0 and MduBusy=0 during the reset cycle and the first cycle after, unless inputs create a hazard.
- Reset mid-operation aborts LOAD_WAIT or MDU_BUSY immediately; no residual stall.
- Simultaneous events:
  - lwHit and MduStartE cannot coincide (E holds one instruction); if both assert, MDU wins and lwHit is ignored.
  - PCSrcE with lwHit in IDLE: both flushes assert and stalls assert. The core treats PCSrcE as higher priority at the PC mux.
  - Counters update on the same edge as the FSM.

## Structure
- hazard_pkg:
  - forward encodings FWD_RF/FWD_W/FWD_M_ALU/FWD_M_IMM
  - result-source encodings RES_LOAD/RES_IMM
  - FSM state enum
- Sub-module fwd_sel: one instance per operand (Rs1E, Rs2E); pure priority compare returning the 2-bit select.
- Top holds the FSM, the two down-counters and the saturating counters.

## Test plan
- Rs1E=5, RdM=5, RegWriteM=1, ResultSrcM=00; RdW=5, RegWriteW=1 → ForwardAE=10 (M beats W). Same with Rs1E=0 → 00.
- RdM=7, RegWriteM=1, ResultSrcM=11, Rs2E=7 → ForwardBE=11. With FWD_IMM=0 → 10.
- LOAD_BUBBLES=2; ResultSrcE=01, RdE=3, Rs2D=3 → StallF/StallD/FlushE high for exactly 2 cycles, then low; StallCycles=2.
- MDU_LAT=4; MduStartE pulse → StallF/StallD/StallE/FlushM high 3 cycles; MduBusy high cycles 2–4; op leaves E on cycle 4.
- rst asserted in the 2nd MDU_BUSY cycle → next cycle state IDLE, all outputs 0, counters 0.
- CNT_W=4; 20 consecutive PCSrcE cycles → FlushEvents saturates at 15.
